// File: rtl/alu_result_buf_if.sv
// Result stream bundle: ALU-side push inputs plus the consumer-side
// valid/ready head-of-queue port.
interface alu_result_buf_if #(
  parameter int WIDTH = 6,
  parameter int TAG_W = 4
);
  logic [WIDTH-1:0] res_in;
  logic             res_valid;
  logic [WIDTH-1:0] m_data;
  logic [TAG_W-1:0] m_tag;
  logic             m_valid;
  logic             m_ready;

  modport master (
    output res_in, res_valid, m_ready,
    input  m_data, m_tag, m_valid
  );

  modport slave (
    input  res_in, res_valid, m_ready,
    output m_data, m_tag, m_valid
  );
endinterface

// File: rtl/alu_result_buf.sv
// Tagged result FIFO behind a non-stallable ALU; results that arrive while
// full are dropped and counted.
module alu_result_buf #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_result_buf_if.slave        bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic [7:0]             drop_cnt,
  input  logic                   clr_ovf
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = WIDTH + TAG_W;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [TAG_W-1:0] seq;
  logic             pop;
  logic             push;
  logic             drop;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);
  assign pop   = !empty && bus.m_ready;
  assign push  = bus.res_valid && (!full || pop);
  assign drop  = bus.res_valid && full && !pop;

  // Head is gated so nothing stale leaks out while the queue is empty.
  assign bus.m_valid = !empty;
  assign bus.m_data  = empty ? '0 : mem[rd_ptr][ENT_W-1:TAG_W];
  assign bus.m_tag   = empty ? '0 : mem[rd_ptr][TAG_W-1:0];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.res_in, seq};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      seq      <= '0;
      level    <= '0;
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      // Tag counts every ALU result, so gaps reveal drops downstream.
      if (bus.res_valid) seq    <= seq + TAG_W'(1);
      if (push)          wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)           rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        drop_cnt <= clr_ovf ? 8'd1 : sat_inc(drop_cnt);
      end else if (clr_ovf) begin
        overflow <= 1'b0;
        drop_cnt <= 8'd0;
      end
    end
  end
endmodule

// File: tb/tb_alu_result_buf.sv
// Directed bench for alu_result_buf: vector table plus hand-written
// sequences for fill/pop, saturation, tag wrap and asynchronous reset.
module tb_alu_result_buf;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [2:0] level;
  logic       full;
  logic       empty;
  logic       overflow;
  logic [7:0] drop_cnt;
  int         tests = 0;
  int         fails = 0;

  alu_result_buf_if #(.WIDTH(6), .TAG_W(4)) bus ();

  alu_result_buf #(.WIDTH(6), .DEPTH(4), .TAG_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .level    (level),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .drop_cnt (drop_cnt),
    .clr_ovf  (clr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         do_rst;
    logic       vin;
    logic [5:0] din;
    logic       rdy;
    logic       clr;
    logic       ev;
    logic [5:0] ed;
    logic [3:0] et;
    logic [2:0] el;
    logic       eo;
    logic [7:0] ec;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, int vin, int din, int rdy, int clr,
                              int ev, int ed, int et, int el, int eo, int ec);
    vec_t v;
    v.do_rst = r;
    v.vin = 1'(vin); v.din = 6'(din); v.rdy = 1'(rdy); v.clr = 1'(clr);
    v.ev = 1'(ev); v.ed = 6'(ed); v.et = 4'(et); v.el = 3'(el);
    v.eo = 1'(eo); v.ec = 8'(ec);
    return v;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic vin, logic [5:0] din, logic rdy, logic clr);
    bus.res_valid = vin;
    bus.res_in    = din;
    bus.m_ready   = rdy;
    clr_ovf       = clr;
  endtask

  task automatic do_reset();
    drive(1'b0, 6'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  function automatic logic [31:0] snap();
    return {7'd0, bus.m_valid, bus.m_data, bus.m_tag, level, full, empty,
            overflow, drop_cnt};
  endfunction

  function automatic logic [31:0] expv(logic ev, logic [5:0] ed, logic [3:0] et,
                                       logic [2:0] el, logic eo, logic [7:0] ec);
    return {7'd0, ev, ed, et, el, (el == 3'd4), (el == 3'd0), eo, ec};
  endfunction

  initial begin
    drive(1'b0, 6'd0, 1'b0, 1'b0);
    #1;
    check("reset_async", snap(), expv(0, 0, 0, 0, 0, 0));
    step();
    step();
    check("reset_held", snap(), expv(0, 0, 0, 0, 0, 0));

    // Ordering after reset, then fill-and-drop with tag gap.
    vecs.push_back(mk(1, 1, 5, 0, 0, 1, 5, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 6, 0, 0, 1, 5, 0, 2, 0, 0));
    vecs.push_back(mk(0, 1, 7, 0, 0, 1, 5, 0, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 6, 1, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 7, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 1, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 2, 0, 0, 1, 1, 0, 2, 0, 0));
    vecs.push_back(mk(0, 1, 3, 0, 0, 1, 1, 0, 3, 0, 0));
    vecs.push_back(mk(0, 1, 4, 0, 0, 1, 1, 0, 4, 0, 0));
    vecs.push_back(mk(0, 1, 5, 0, 0, 1, 1, 0, 4, 1, 1));
    vecs.push_back(mk(0, 1, 6, 0, 0, 1, 1, 0, 4, 1, 2));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 2, 1, 3, 1, 2));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 3, 2, 2, 1, 2));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 4, 3, 1, 1, 2));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 2));
    vecs.push_back(mk(0, 1, 7, 0, 0, 1, 7, 6, 1, 1, 2));

    foreach (vecs[i]) begin
      if (vecs[i].do_rst) do_reset();
      drive(vecs[i].vin, vecs[i].din, vecs[i].rdy, vecs[i].clr);
      step();
      check($sformatf("vec%0d", i), snap(),
            expv(vecs[i].ev, vecs[i].ed, vecs[i].et, vecs[i].el,
                 vecs[i].eo, vecs[i].ec));
    end

    // Push while full with simultaneous pop.
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 6'(i), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 6'd9, 1'b1, 1'b0);
    step();
    check("full_pop_push", snap(), expv(1, 2, 1, 4, 0, 0));
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 6'd0, 1'b0, 1'b0);
      check($sformatf("full_pop_drain%0d", i), {24'd0, 2'b00, bus.m_data},
            (i == 3) ? 32'd9 : 32'(i + 2));
      if (i == 3) check("full_pop_tag", {28'd0, bus.m_tag}, 32'd4);
      drive(1'b0, 6'd0, 1'b1, 1'b0);
      step();
    end
    check("full_pop_empty", snap(), expv(0, 0, 0, 0, 0, 0));

    // Drop counter saturation and clear priority.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 6'(i + 20), 1'b0, 1'b0);
      step();
    end
    for (int i = 0; i < 300; i++) step();
    check("sat_cnt", {24'd0, drop_cnt}, 32'd255);
    check("sat_ovf", {31'd0, overflow}, 32'd1);
    drive(1'b0, 6'd0, 1'b0, 1'b1);
    step();
    check("clr_only", {23'd0, overflow, drop_cnt}, 32'd0);
    check("clr_keeps_data", snap(), expv(1, 20, 0, 4, 0, 0));
    drive(1'b1, 6'd33, 1'b0, 1'b1);
    step();
    check("clr_with_drop", {23'd0, overflow, drop_cnt}, {23'd0, 1'b1, 8'd1});
    drive(1'b0, 6'd0, 1'b0, 1'b0);

    // Streaming with tag wrap.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 6'(i), 1'b1, 1'b0);
      step();
      check($sformatf("stream%0d", i), snap(),
            expv(1, 6'(i), 4'(i % 16), 1, 0, 0));
    end
    drive(1'b0, 6'd0, 1'b1, 1'b0);
    step();
    check("stream_end", snap(), expv(0, 0, 0, 0, 0, 0));

    // Asynchronous reset between edges.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'(i + 40), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 6'd0, 1'b0, 1'b0);
    check("pre_async_level", {29'd0, level}, 32'd3);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst", snap(), expv(0, 0, 0, 0, 0, 0));
    step();
    rst = 1'b1;
    drive(1'b1, 6'd11, 1'b0, 1'b0);
    step();
    check("post_async_tag", snap(), expv(1, 11, 0, 1, 0, 0));
    drive(1'b0, 6'd0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
